m_key_repeat_counter: RTL and testbench

M_KEY_REPEAT_COUNTER -- requirements
Module: m_key_repeat_counter

---
 rtl/key_pkg.sv | 12 +
 rtl/m_bcd2_counter.sv | 41 ++++
 rtl/m_key_repeat_counter.sv | 103 ++++++++++
 tb/tb_m_key_repeat_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared encodings for the key auto-repeat counter: FSM state and BCD digit limit.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/m_bcd2_counter.sv
// Two-digit BCD event counter, 00..99, with one-cycle carry on wrap and clear priority.
module m_bcd2_counter
  import key_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q_ones,
  output logic [3:0] q_tens,
  output logic       carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ones <= 4'd0;
      q_tens <= 4'd0;
      carry  <= 1'b0;
    end else begin
      carry <= 1'b0;
      // clear wins over a same-cycle increment and suppresses the wrap carry
      if (clr) begin
        q_ones <= 4'd0;
        q_tens <= 4'd0;
      end else if (en) begin
        if (q_ones == BCD_MAX) begin
          q_ones <= 4'd0;
          if (q_tens == BCD_MAX) begin
            q_tens <= 4'd0;
            carry  <= 1'b1;
          end else begin
            q_tens <= q_tens + 4'd1;
          end
        end else begin
          q_ones <= q_ones + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/m_key_repeat_counter.sv
// Key press / auto-repeat pulse generator feeding a 2-digit BCD press counter.
module m_key_repeat_counter
  import key_pkg::*;
#(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_in,
  input  logic       clr,
  output logic       key_pulse,
  output logic [3:0] q_ones,
  output logic [3:0] q_tens,
  output logic       carry,
  output logic       repeating
);

  localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW      = $clog2(MAX_CYC);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

  if (HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_param
    $error("m_key_repeat_counter: HOLD_CYC and REPEAT_CYC must both be >= 2");
  end

  logic [1:0]    sync_q;
  logic          lvl;
  logic          lvl_d;
  key_state_e    state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], sw_in};
  end

  assign lvl = sync_q[1];

  // release is tested before expiry in PRESS/REPEAT so it always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      key_pulse <= 1'b0;
      repeating <= 1'b0;
      lvl_d     <= 1'b0;
    end else begin
      lvl_d     <= lvl;
      key_pulse <= 1'b0;
      case (state)
        IDLE: begin
          repeating <= 1'b0;
          if (lvl && !lvl_d) begin
            key_pulse <= 1'b1;
            state     <= PRESS;
            timer     <= '0;
          end
        end
        PRESS: begin
          if (!lvl) begin
            state     <= IDLE;
            repeating <= 1'b0;
          end else if (timer == HOLD_LAST) begin
            key_pulse <= 1'b1;
            state     <= REPEAT;
            repeating <= 1'b1;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!lvl) begin
            state     <= IDLE;
            repeating <= 1'b0;
          end else if (timer == REP_LAST) begin
            key_pulse <= 1'b1;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          repeating <= 1'b0;
        end
      endcase
    end
  end

  m_bcd2_counter u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (key_pulse),
    .clr    (clr),
    .q_ones (q_ones),
    .q_tens (q_tens),
    .carry  (carry)
  );

endmodule

// File: tb/tb_m_key_repeat_counter.sv
// Directed bench for m_key_repeat_counter with HOLD_CYC=8, REPEAT_CYC=4.
module tb_m_key_repeat_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_in;
  logic       clr;
  logic       key_pulse;
  logic [3:0] q_ones;
  logic [3:0] q_tens;
  logic       carry;
  logic       repeating;

  int checks = 0;
  int errors = 0;

  m_key_repeat_counter #(.HOLD_CYC(8), .REPEAT_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .clr       (clr),
    .key_pulse (key_pulse),
    .q_ones    (q_ones),
    .q_tens    (q_tens),
    .carry     (carry),
    .repeating (repeating)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then park on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_once();
    sw_in = 1'b1;
    repeat (3) step();
    sw_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_kp"},  8'(key_pulse), 8'd0);
    chk({tag, "_cnt"}, {q_tens, q_ones}, 8'h00);
    chk({tag, "_cy"},  8'(carry), 8'd0);
    chk({tag, "_rep"}, 8'(repeating), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 1'b0;
    clr   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    chk_zero("reset");

    // short press: high for edges 1..5
    sw_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("short_kp_e%0d", e), 8'(key_pulse), 8'(e == 3));
      chk($sformatf("short_rep_e%0d", e), 8'(repeating), 8'd0);
      if (e == 5) sw_in = 1'b0;
    end
    chk("short_cnt", {q_tens, q_ones}, 8'h01);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", {q_tens, q_ones}, 8'h00);

    // long press: high for edges 1..20, expiry at edge 23 loses to release
    sw_in = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step();
      chk($sformatf("long_kp_e%0d", e), 8'(key_pulse),
          8'(e == 3 || e == 11 || e == 15 || e == 19));
      chk($sformatf("long_rep_e%0d", e), 8'(repeating), 8'(e >= 11 && e <= 22));
      if (e == 20) sw_in = 1'b0;
    end
    chk("long_cnt", {q_tens, q_ones}, 8'h04);

    // clr during the key_pulse cycle after edge 11
    sw_in = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      chk($sformatf("clrp_kp_e%0d", e), 8'(key_pulse), 8'(e == 3 || e == 11 || e == 15));
      chk($sformatf("clrp_rep_e%0d", e), 8'(repeating), 8'(e >= 11 && e <= 18));
      if (e == 11) begin
        chk("clrp_cnt_pre", {q_tens, q_ones}, 8'h05);
        clr = 1'b1;
      end
      if (e == 12) begin
        clr = 1'b0;
        chk("clrp_cnt", {q_tens, q_ones}, 8'h00);
        chk("clrp_cy", 8'(carry), 8'd0);
      end
      if (e == 16) sw_in = 1'b0;
    end
    chk("clrp_cnt_end", {q_tens, q_ones}, 8'h01);

    // asynchronous reset while in REPEAT with the key still held
    sw_in = 1'b1;
    repeat (12) step();
    chk("rst_pre_rep", 8'(repeating), 8'd1);
    chk("rst_pre_cnt", {q_tens, q_ones}, 8'h03);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("rst_kp_e%0d", e), 8'(key_pulse), 8'(e == 3));
      chk($sformatf("rst_cnt_e%0d", e), {q_tens, q_ones}, (e >= 4) ? 8'h01 : 8'h00);
    end
    sw_in = 1'b0;
    repeat (4) step();

    // wrap: 99 presses, then the 100th
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) press_once();
    chk("wrap_cnt10", {q_tens, q_ones}, 8'h10);
    repeat (89) press_once();
    chk("wrap_cnt99", {q_tens, q_ones}, 8'h99);
    chk("wrap_cy99", 8'(carry), 8'd0);
    sw_in = 1'b1;
    repeat (3) step();
    chk("wrap_kp", 8'(key_pulse), 8'd1);
    step();
    chk("wrap_cnt00", {q_tens, q_ones}, 8'h00);
    chk("wrap_cy", 8'(carry), 8'd1);
    step();
    chk("wrap_cy_end", 8'(carry), 8'd0);
    sw_in = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
